iter_div: RTL



---
 rtl/iter_div_pkg.sv | 14 +
 rtl/iter_div_if.sv | 24 ++
 rtl/iter_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/iter_div_pkg.sv
// rtl/iter_div_pkg.sv - shared state encodings and constants for the iterative divider
package iter_div_pkg;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_BUSY = 2'd1;
    localparam logic [1:0] DIV_ST_FIX  = 2'd2;
    localparam logic [1:0] DIV_ST_DONE = 2'd3;

    localparam int DIV_DATA_WD = 32;
    localparam int DIV_LATENCY = DIV_DATA_WD + 2;

endpackage

// File: rtl/iter_div_if.sv
// rtl/iter_div_if.sv - execute-stage request/result bundle for the iterative divider
interface iter_div_if #(
    parameter int DATA_WD = 32
);
    logic               div_enable;
    logic               div_sign;
    logic [DATA_WD-1:0] div_src1;
    logic [DATA_WD-1:0] div_src2;
    logic               div_ready;
    logic               div_complete;
    logic [DATA_WD-1:0] div_quot;
    logic [DATA_WD-1:0] div_rem;
    logic               div_busy;

    modport master (
        output div_enable, div_sign, div_src1, div_src2, div_ready,
        input  div_complete, div_quot, div_rem, div_busy
    );

    modport slave (
        input  div_enable, div_sign, div_src1, div_src2, div_ready,
        output div_complete, div_quot, div_rem, div_busy
    );
endinterface

// File: rtl/iter_div.sv
// rtl/iter_div.sv - radix-2 restoring divider, optional early finish under DIV_FAST_PATH_EN
module iter_div
    import iter_div_pkg::*;
#(
    parameter int DATA_WD = DIV_DATA_WD,
    parameter int CNT_WD  = $clog2(DATA_WD)
) (
    input  logic       clk,
    input  logic       reset,
    iter_div_if.slave  div
);

    div_state_t         state_q, state_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic [DATA_WD-1:0] prem_q, prem_d;
    logic [DATA_WD-1:0] dvd_q, dvd_d;
    logic [DATA_WD-1:0] dvs_q, dvs_d;
    logic [DATA_WD-1:0] src1_q, src1_d;
    logic [DATA_WD-1:0] quot_q, quot_d;
    logic [DATA_WD-1:0] rem_q, rem_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               zero_q, zero_d;
    logic               complete_q, complete_d;

    logic [DATA_WD-1:0] mag_a, mag_b;
    logic [DATA_WD:0]   trial;
    logic [DATA_WD+1:0] diff;
    logic               trial_neg;

    assign mag_a = (div.div_sign && div.div_src1[DATA_WD-1]) ? -div.div_src1 : div.div_src1;
    assign mag_b = (div.div_sign && div.div_src2[DATA_WD-1]) ? -div.div_src2 : div.div_src2;

    // Two guard bits: the shifted remainder can exceed DATA_WD bits before the subtract.
    assign trial     = {prem_q, dvd_q[DATA_WD-1]};
    assign diff      = {1'b0, trial} - {2'b00, dvs_q};
    assign trial_neg = diff[DATA_WD+1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        src1_d     = src1_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        zero_d     = zero_q;
        complete_d = complete_q;

        case (state_q)
            DIV_ST_IDLE: begin
                complete_d = 1'b0;
                if (div.div_enable) begin
                    dvd_d   = mag_a;
                    dvs_d   = mag_b;
                    src1_d  = div.div_src1;
                    prem_d  = '0;
                    cnt_d   = '0;
                    negq_d  = div.div_sign & (div.div_src1[DATA_WD-1] ^ div.div_src2[DATA_WD-1]);
                    negr_d  = div.div_sign & div.div_src1[DATA_WD-1];
                    zero_d  = (div.div_src2 == '0);
                    state_d = DIV_ST_BUSY;
`ifdef DIV_FAST_PATH_EN
                    if ((div.div_src2 == '0) || (mag_a < mag_b)) begin
                        quot_d     = (div.div_src2 == '0) ? '1 : '0;
                        rem_d      = div.div_src1;
                        complete_d = 1'b1;
                        state_d    = DIV_ST_DONE;
                    end
`endif
                end
            end
            DIV_ST_BUSY: begin
                if (!div.div_enable) begin
                    state_d = DIV_ST_IDLE;
                end else begin
                    prem_d = trial_neg ? trial[DATA_WD-1:0] : diff[DATA_WD-1:0];
                    dvd_d  = {dvd_q[DATA_WD-2:0], ~trial_neg};
                    cnt_d  = cnt_q + CNT_WD'(1);
                    if (cnt_q == CNT_WD'(DATA_WD - 1)) begin
                        state_d = DIV_ST_FIX;
                    end
                end
            end
            DIV_ST_FIX: begin
                if (!div.div_enable) begin
                    state_d = DIV_ST_IDLE;
                end else begin
                    if (zero_q) begin
                        quot_d = '1;
                        rem_d  = src1_q;
                    end else begin
                        quot_d = negq_q ? -dvd_q : dvd_q;
                        rem_d  = negr_q ? -prem_q : prem_q;
                    end
                    complete_d = 1'b1;
                    state_d    = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                if (!div.div_enable || div.div_ready) begin
                    complete_d = 1'b0;
                    state_d    = DIV_ST_IDLE;
                end
            end
            default: begin
                complete_d = 1'b0;
                state_d    = DIV_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIV_ST_IDLE;
            cnt_q      <= '0;
            prem_q     <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            src1_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            zero_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            src1_q     <= src1_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            zero_q     <= zero_d;
            complete_q <= complete_d;
        end
    end

    assign div.div_complete = complete_q;
    assign div.div_quot     = quot_q;
    assign div.div_rem      = rem_q;
    assign div.div_busy     = (state_q == DIV_ST_BUSY) || (state_q == DIV_ST_FIX);

endmodule
